rtc_bus_scheduler: RTL
======================

# rtc_bus_scheduler

Sequences and shares the single RTC bus-transaction engine between two requesters: the periodic time/date refresh (read burst) and the user programming path (write burst). Each burst walks the RTC register bank one transaction at a time. For each transaction it issues a start pulse, waits for the engine's done pulse, then advances the register index. It sits between the general write/program control FSM (which drives `wr_req` and consumes `wr_done` as its end-of-programming flag) and the low-level bus-cycle engine.

## Interface
Parameters:
- `N_REGS`, default 9: registers per burst; `reg_idx` runs 0..N_REGS-1.
- `BASE_ADDR`, default 8'h21: RTC address of index 0; `tx_addr` = BASE_ADDR + reg_idx, 8-bit wrap.
- `CMD_ADDR`, default 8'hF0: transfer-command address (macro feature only).
- `REFRESH_CYCLES`, default 100000: period of the read-refresh request, in clocks.
- `TIMEOUT_CYCLES`, default 1024: maximum clocks to wait for `tx_done`.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `en` in 1: scheduler enable.
- `wr_req` in 1: level request for a write burst.
- `tx_done` in 1: one-cycle completion pulse from the engine.
- `tx_start` out 1: one-cycle transaction start pulse.
- `tx_write` out 1: 1 = write, 0 = read; valid while `busy`.
- `tx_addr` out 8: transaction address.
- `reg_idx` out 4: register index; selects the write-data mux and the read capture slot.
- `cmd_phase` out 1: current transaction is the transfer command.
- `rd_valid` out 1: one-cycle pulse. Capture engine read data into slot `reg_idx`.
- `busy` out 1: a burst is active.
- `wr_done` out 1: one-cycle pulse when a write burst completes.
- `rd_done` out 1: one-cycle pulse when a read burst completes.
- `err` out 1: one-cycle pulse on transaction timeout.

## Operation
- States: IDLE, WAIT (transaction outstanding), GAP (one idle cycle between transactions).
- Pending flags:
  - `wr_pending` sets when `wr_req`=1 and no write burst is active. `wr_req` during a write burst is ignored.
  - `rd_pending` sets when the refresh counter reaches REFRESH_CYCLES-1. The counter then wraps to 0.
  - Neither flag stacks. Each flag clears when its burst starts.
- IDLE with any pending flag: start a burst. Write has priority over read.
  - On burst start: `reg_idx`=0, `tx_write` set per burst type, `tx_start`=1, `busy`=1, go to WAIT.
- WAIT on `tx_done`:
  - Read burst, non-command transaction: pulse `rd_valid` with the current `reg_idx`.
  - If `reg_idx`=N_REGS-1: pulse `wr_done`/`rd_done`, clear `busy`, go to IDLE.
  - Otherwise: go to GAP.
- GAP: `reg_idx`+1, `tx_start`=1, go to WAIT.
- Timeout: a counter clears on each `tx_start`. If it reaches TIMEOUT_CYCLES-1 in WAIT without `tx_done`:
  - pulse `err`, abort the burst, go to IDLE;
  - no done pulse; the aborted request is not re-queued.
- `en`=0:
  - refresh counter held at 0; pending flags cleared; no new burst or transaction issued;
  - an outstanding transaction finishes (or times out), then go to IDLE with no done pulse.
- `tx_done` in IDLE or GAP is ignored.

## Timing
- All outputs registered. Reset values: all outputs 0; state IDLE; counters 0; pending flags 0.
- `wr_req` high at edge k, scheduler in IDLE: `wr_pending` is set at edge k, and `tx_start` goes high after edge k+1 for exactly one cycle.
- `tx_addr`, `tx_write`, `reg_idx`, `cmd_phase` are stable from `tx_start` until the edge after `tx_done`.
- `tx_done` coincident with `tx_start` is accepted.
- Per transaction: the engine's latency after `tx_start`, plus 1 GAP cycle.
- Done and `rd_valid` pulses appear the cycle after `tx_done` is sampled.
- Refresh expiry and `wr_req` in the same cycle: the write burst runs first. The read burst starts 1 cycle after `wr_done`.
- Reset mid-burst: immediate return to reset values. The engine shares the same reset.

## Configuration
- `RTC_XFER_CMD_EN` defined:
  - every burst begins with one extra write transaction to CMD_ADDR, with `cmd_phase`=1 and `reg_idx` held at 0;
  - that transaction produces no `rd_valid`;
  - after its `tx_done`, a GAP cycle follows, then index 0.
- Not defined: `cmd_phase` tied 0; bursts start directly at index 0.

## Test plan
- Bench parameters: N_REGS=3, REFRESH_CYCLES=50, TIMEOUT_CYCLES=16; engine returns `tx_done` 4 cycles after `tx_start`.
- Write burst: `wr_req` pulse, `en`=1 → three `tx_start` pulses with `tx_addr` 21, 22, 23, `tx_write`=1; one `wr_done`; `busy` low afterwards.
- Refresh: idle for 50 cycles → read burst with addresses 21–23, `tx_write`=0; `rd_valid` with `reg_idx` 0, 1, 2; one `rd_done`.
- Collision: `wr_req` in the same cycle as refresh expiry → full write burst, then the read burst 1 cycle after `wr_done`.
- Timeout: engine withholds `tx_done` on index 1 → `err` pulse 16 cycles after that `tx_start`; no `wr_done`; next `wr_req` restarts at index 0.
- Abort: `en` dropped during index 1 → index 1 completes, no index 2, no done pulse. `reset` mid-burst → all outputs 0 the next cycle.
- With `RTC_XFER_CMD_EN`: the first transaction has `tx_addr`=F0 and `cmd_phase`=1; a read burst gives exactly 3 `rd_valid` pulses.

Source files
------------

// File: rtl/rtc_bus_scheduler.sv
// Shares the RTC bus engine between periodic read-refresh bursts and user write bursts, one register per transaction.
// Optional macro RTC_XFER_CMD_EN prefixes every burst with a transfer-command write to CMD_ADDR.
module rtc_bus_scheduler #(
  parameter int         N_REGS         = 9,
  parameter logic [7:0] BASE_ADDR      = 8'h21,
  parameter logic [7:0] CMD_ADDR       = 8'hF0,
  parameter int         REFRESH_CYCLES = 100000,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       wr_req,
  input  logic       tx_done,
  output logic       tx_start,
  output logic       tx_write,
  output logic [7:0] tx_addr,
  output logic [3:0] reg_idx,
  output logic       cmd_phase,
  output logic       rd_valid,
  output logic       busy,
  output logic       wr_done,
  output logic       rd_done,
  output logic       err
);

`ifdef RTC_XFER_CMD_EN
  localparam logic CMD_EN = 1'b1;
`else
  localparam logic CMD_EN = 1'b0;
`endif

  localparam int RC_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RC_W-1:0] REFRESH_LAST = RC_W'(REFRESH_CYCLES - 1);
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      IDX_LAST     = 4'(N_REGS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t          state;
  logic            burst_wr;
  logic            wr_pending;
  logic            rd_pending;
  logic [RC_W-1:0] refresh_cnt;
  logic [TO_W-1:0] tmo_cnt;

  logic       refresh_expire;
  logic       wr_start;
  logic       rd_start;
  logic [3:0] idx_next;

  assign refresh_expire = en && (refresh_cnt == REFRESH_LAST);
  assign wr_start       = (state == IDLE) && en && wr_pending;
  assign rd_start       = (state == IDLE) && en && !wr_pending && rd_pending;
  // The command transaction keeps the index at 0, so the first data register follows it.
  assign idx_next       = cmd_phase ? 4'd0 : reg_idx + 4'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_write    <= 1'b0;
      tx_addr     <= 8'd0;
      reg_idx     <= 4'd0;
      cmd_phase   <= 1'b0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      wr_done     <= 1'b0;
      rd_done     <= 1'b0;
      err         <= 1'b0;
      burst_wr    <= 1'b0;
      wr_pending  <= 1'b0;
      rd_pending  <= 1'b0;
      refresh_cnt <= '0;
      tmo_cnt     <= '0;
    end else begin
      tx_start <= 1'b0;
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      err      <= 1'b0;

      if (!en || refresh_expire) refresh_cnt <= '0;
      else                       refresh_cnt <= refresh_cnt + RC_W'(1);

      if (!en)                                 wr_pending <= 1'b0;
      else if (wr_start)                       wr_pending <= 1'b0;
      else if (wr_req && !(busy && burst_wr))  wr_pending <= 1'b1;

      // A refresh expiring on the same edge a read burst starts is kept, not lost.
      if (!en)                 rd_pending <= 1'b0;
      else if (refresh_expire) rd_pending <= 1'b1;
      else if (rd_start)       rd_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (wr_start || rd_start) begin
            state     <= WAIT;
            busy      <= 1'b1;
            burst_wr  <= wr_pending;
            tx_write  <= wr_pending | CMD_EN;
            cmd_phase <= CMD_EN;
            reg_idx   <= 4'd0;
            tx_addr   <= CMD_EN ? CMD_ADDR : BASE_ADDR;
            tx_start  <= 1'b1;
            tmo_cnt   <= '0;
          end
        end
        WAIT: begin
          if (tx_done) begin
            rd_valid <= !burst_wr && !cmd_phase;
            if (!en || (!cmd_phase && reg_idx == IDX_LAST)) begin
              state   <= IDLE;
              busy    <= 1'b0;
              wr_done <= en && burst_wr;
              rd_done <= en && !burst_wr;
            end else begin
              state <= GAP;
            end
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TO_W'(1);
          end
        end
        GAP: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= WAIT;
            tx_start  <= 1'b1;
            tmo_cnt   <= '0;
            tx_write  <= burst_wr;
            cmd_phase <= 1'b0;
            reg_idx   <= idx_next;
            tx_addr   <= BASE_ADDR + {4'd0, idx_next};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
